// File: rtl/digit_serial_adder.sv
// Digit-serial sequencer for a 2-bit carry-in/carry-out adder. The adder
// is external and is wired through the io_add_* ports. A W-bit operand pair
// is fed to it one 2-bit digit per clock, least significant digit first.
// The carry is chained from digit to digit, and the W-bit sum is assembled
// with its final carry-out.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. The producer holds valid and data stable until that edge.
// io_in_ready is 1 only in IDLE, and io_out_valid is 1 only in DONE. The
// two are never 1 together, so a result hand-off and a new accept cannot
// share an edge.
module digit_serial_adder #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_a,
  input  logic [W-1:0] io_in_b,
  input  logic         io_in_cin,
  output logic         io_out_valid,
  input  logic         io_out_ready,
  output logic [W-1:0] io_out_sum,
  output logic         io_out_cout,
  output logic [1:0]   io_add_lhs,
  output logic [1:0]   io_add_rhs,
  output logic         io_add_cin,
  input  logic [1:0]   io_add_out,
  input  logic         io_add_cout
);
  localparam int D  = W / 2;
  localparam int KW = (D > 1) ? $clog2(D) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(D - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  sum_reg;
  logic          carry_reg;
  // The result registers are separate from sum_reg and carry_reg.
  // Partial sums and carries therefore never appear on io_out_*. The last
  // result stays visible after DONE until the next accept clears it.
  logic [W-1:0]  res_sum;
  logic          res_cout;

  logic [W-1:0]  sum_next;
  logic [KW:0]   bit_idx;
  logic          running;

  assign bit_idx = {k, 1'b0};
  assign running = (state == RUN);

  // Merge the adder's current digit into the partial sum.
  always_comb begin
    sum_next = sum_reg;
    sum_next[bit_idx +: 2] = io_add_out;
  end

  // Sequencer: accept operands, walk D digits, present the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      k         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      res_sum   <= '0;
      res_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (io_in_valid) begin
            a_reg     <= io_in_a;
            b_reg     <= io_in_b;
            carry_reg <= io_in_cin;
            sum_reg   <= '0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            k         <= '0;
            state     <= RUN;
          end
        end
        RUN: begin
          sum_reg   <= sum_next;
          carry_reg <= io_add_cout;
          if (k == K_LAST) begin
            res_sum  <= sum_next;
            res_cout <= io_add_cout;
            state    <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (io_out_ready) begin
            k     <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign io_out_sum   = res_sum;
  assign io_out_cout  = res_cout;

  // The adder sees a live digit only while running; otherwise it sees zeros.
  assign io_add_lhs = running ? a_reg[bit_idx +: 2] : 2'b00;
  assign io_add_rhs = running ? b_reg[bit_idx +: 2] : 2'b00;
  assign io_add_cin = running & carry_reg;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder. It runs three instances (W=8, 16, 2). Each
// instance has a behavioural 2-bit adder attached, as the external
// adder stage would be.
module tb_digit_serial_adder;
  localparam int NI   = 3;
  localparam int WMAX = 16;

  logic clk = 1'b0;
  logic rst_n;

  logic            in_valid [NI];
  logic            in_ready [NI];
  logic [WMAX-1:0] in_a     [NI];
  logic [WMAX-1:0] in_b     [NI];
  logic            in_cin   [NI];
  logic            out_valid[NI];
  logic            out_ready[NI];
  logic [WMAX-1:0] out_sum  [NI];
  logic            out_cout [NI];
  logic [1:0]      add_lhs  [NI];
  logic [1:0]      add_rhs  [NI];
  logic            add_cin  [NI];
  logic [1:0]      add_out  [NI];
  logic            add_cout [NI];

  int total = 0;
  int bad   = 0;
  logic [WMAX:0] exp_q[$];

  typedef struct {
    int            g;
    logic [15:0]   a;
    logic [15:0]   b;
    logic          cin;
    int            stall;
    bit            junk;
    logic [WMAX:0] exp;
  } vec_t;

  function automatic int wid(input int g);
    return (g == 0) ? 8 : ((g == 1) ? 16 : 2);
  endfunction

  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int WG = (g == 0) ? 8 : ((g == 1) ? 16 : 2);
      logic [WG-1:0] sum_l;
      digit_serial_adder #(.W(WG)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .io_in_valid (in_valid[g]),
        .io_in_ready (in_ready[g]),
        .io_in_a     (in_a[g][WG-1:0]),
        .io_in_b     (in_b[g][WG-1:0]),
        .io_in_cin   (in_cin[g]),
        .io_out_valid(out_valid[g]),
        .io_out_ready(out_ready[g]),
        .io_out_sum  (sum_l),
        .io_out_cout (out_cout[g]),
        .io_add_lhs  (add_lhs[g]),
        .io_add_rhs  (add_rhs[g]),
        .io_add_cin  (add_cin[g]),
        .io_add_out  (add_out[g]),
        .io_add_cout (add_cout[g])
      );
      assign out_sum[g] = WMAX'(sum_l);
      assign {add_cout[g], add_out[g]} = {1'b0, add_lhs[g]} + {1'b0, add_rhs[g]} + {2'b00, add_cin[g]};
    end
  endgenerate

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [WMAX:0] act, input logic [WMAX:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [WMAX:0] result_of(input int g);
    return (WMAX+1)'(out_sum[g]) | ((WMAX+1)'(out_cout[g]) << wid(g));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle_all();
    for (int i = 0; i < NI; i++) begin
      in_valid[i]  = 1'b0;
      in_a[i]      = '0;
      in_b[i]      = '0;
      in_cin[i]    = 1'b0;
      out_ready[i] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One operation on instance g, called and returning at a negedge in IDLE.
  // Digits and the carry into each digit come from plain arithmetic on a, b, cin.
  task automatic run_op(input int g, input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input int stall, input bit junk,
                        input logic [WMAX:0] exp, output logic [WMAX:0] res);
    int dg;
    int e;
    logic [WMAX:0] m;
    logic [WMAX:0] part;
    dg = wid(g) / 2;
    check("accept_ready", (WMAX+1)'(in_ready[g]), 1);
    in_a[g] = a; in_b[g] = b; in_cin[g] = cin; in_valid[g] = 1'b1; out_ready[g] = 1'b0;
    @(posedge clk); @(negedge clk);
    if (junk) begin
      in_a[g] = ~a; in_b[g] = a ^ 16'h5a5a; in_cin[g] = ~cin;
    end else begin
      in_valid[g] = 1'b0;
    end
    check("run_result_cleared", result_of(g), 0);
    e = 0;
    while (!out_valid[g] && e < dg + 4) begin
      if (e < dg) begin
        m    = ((WMAX+1)'(1) << (2 * e)) - (WMAX+1)'(1);
        part = ({1'b0, a} & m) + ({1'b0, b} & m) + (WMAX+1)'(cin);
        check("digit_lhs", (WMAX+1)'(add_lhs[g]), (WMAX+1)'((a >> (2 * e)) & 16'd3));
        check("digit_rhs", (WMAX+1)'(add_rhs[g]), (WMAX+1)'((b >> (2 * e)) & 16'd3));
        check("digit_carry_in", (WMAX+1)'(add_cin[g]), (WMAX+1)'(part[2 * e]));
      end
      check("busy_not_ready", (WMAX+1)'(in_ready[g]), 0);
      @(posedge clk); @(negedge clk);
      e++;
    end
    // Valid appears D edges after the accept edge (D+1 counting the accept edge).
    check("latency_edges", (WMAX+1)'(e), (WMAX+1)'(dg));
    for (int s = 0; s < stall; s++) begin
      check("stall_valid", (WMAX+1)'(out_valid[g]), 1);
      check("stall_result", result_of(g), exp);
      check("stall_not_ready", (WMAX+1)'(in_ready[g]), 0);
      @(posedge clk); @(negedge clk);
    end
    check("done_valid", (WMAX+1)'(out_valid[g]), 1);
    check("done_add_idle", (WMAX+1)'({add_lhs[g], add_rhs[g], add_cin[g]}), 0);
    res = result_of(g);
    out_ready[g] = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready[g] = 1'b0;
    in_valid[g]  = 1'b0;
    check("ack_valid_low", (WMAX+1)'(out_valid[g]), 0);
    check("ack_back_idle", (WMAX+1)'(in_ready[g]), 1);
    check("ack_result_retained", result_of(g), exp);
  endtask

  // Random traffic with random output stalls against an a+b+cin reference queue.
  task automatic run_random(input int g, input int n);
    int w;
    int sent;
    int got;
    int cyc;
    logic [15:0] mask;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rc;
    logic [WMAX:0] act;
    w = wid(g);
    sent = 0; got = 0; cyc = 0;
    mask = 16'((32'd1 << w) - 32'd1);
    exp_q.delete();
    while (got < n && cyc < 20000) begin
      out_ready[g] = ($urandom_range(0, 3) != 0);
      if (out_valid[g] && out_ready[g]) begin
        act = result_of(g);
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL random_extra_result: got %h expected none", act);
        end else begin
          check("random_result", act, exp_q.pop_front());
        end
        got++;
      end
      ra = 16'($urandom) & mask;
      rb = 16'($urandom) & mask;
      rc = 1'($urandom_range(0, 1));
      in_a[g] = ra; in_b[g] = rb; in_cin[g] = rc;
      in_valid[g] = (sent < n) && ($urandom_range(0, 2) != 0);
      if (in_valid[g] && in_ready[g]) begin
        exp_q.push_back((WMAX+1)'(ra) + (WMAX+1)'(rb) + (WMAX+1)'(rc));
        sent++;
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid[g] = 1'b0;
    out_ready[g] = 1'b0;
    check("random_count", (WMAX+1)'(got), (WMAX+1)'(n));
    check("random_queue_drained", (WMAX+1)'(exp_q.size()), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t vecs[10];
    logic [WMAX:0] res;

    vecs[0] = '{0, 16'h0037, 16'h0048, 1'b0, 0, 1'b0, 17'h0007F};
    vecs[1] = '{0, 16'h00A5, 16'h005A, 1'b1, 0, 1'b0, 17'h00100};
    vecs[2] = '{0, 16'h00FF, 16'h0001, 1'b0, 6, 1'b1, 17'h00100};
    vecs[3] = '{2, 16'h0003, 16'h0003, 1'b1, 0, 1'b0, 17'h00007};
    vecs[4] = '{1, 16'hFFFF, 16'h0001, 1'b0, 2, 1'b0, 17'h10000};
    vecs[5] = '{1, 16'h1234, 16'h4321, 1'b1, 0, 1'b1, 17'h05556};
    vecs[6] = '{0, 16'h0000, 16'h0000, 1'b0, 0, 1'b0, 17'h00000};
    vecs[7] = '{0, 16'h00FF, 16'h00FF, 1'b1, 1, 1'b0, 17'h001FF};
    vecs[8] = '{2, 16'h0002, 16'h0001, 1'b0, 3, 1'b1, 17'h00003};
    vecs[9] = '{1, 16'h8000, 16'h8000, 1'b0, 0, 1'b0, 17'h10000};

    do_reset();
    for (int i = 0; i < NI; i++) begin
      check("reset_in_ready", (WMAX+1)'(in_ready[i]), 1);
      check("reset_out_valid", (WMAX+1)'(out_valid[i]), 0);
      check("reset_result", result_of(i), 0);
      check("reset_add_drive", (WMAX+1)'({add_lhs[i], add_rhs[i], add_cin[i]}), 0);
    end

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].g, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, vecs[i].junk, vecs[i].exp, res);
      check("table_result", res, vecs[i].exp);
    end

    // Reset asserted in the second RUN cycle abandons the operation.
    in_a[0] = 16'h0055; in_b[0] = 16'h0033; in_cin[0] = 1'b1; in_valid[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid[0] = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrun_reset_valid", (WMAX+1)'(out_valid[0]), 0);
    check("midrun_reset_result", result_of(0), 0);
    check("midrun_reset_ready", (WMAX+1)'(in_ready[0]), 1);
    check("midrun_reset_add", (WMAX+1)'({add_lhs[0], add_rhs[0], add_cin[0]}), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      check("post_reset_no_valid", (WMAX+1)'(out_valid[0]), 0);
    end
    run_op(0, 16'h0001, 16'h0002, 1'b0, 0, 1'b0, 17'h00003, res);
    check("post_reset_result", res, 17'h00003);

    run_random(0, 450);
    run_random(1, 450);
    run_random(2, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
